// File: rtl/memory_port_arbiter_if.sv
// Requester and memory-side signals of the core memory port arbiter.
// The slave modport is the arbiter's view; master is the requester/memory environment.
interface memory_port_arbiter_if;
    logic         cpu_req;
    logic         cpu_we;
    logic [15:31] cpu_addr;
    logic [0:31]  cpu_wdata;
    logic         cpu_ack;
    logic [0:31]  cpu_rdata;
    logic         iop_req;
    logic         iop_we;
    logic [15:31] iop_addr;
    logic [0:31]  iop_wdata;
    logic         iop_ack;
    logic [0:31]  iop_rdata;
    logic         mem_en;
    logic         mem_we;
    logic [15:31] mem_addr;
    logic [0:31]  mem_wdata;
    logic [0:31]  mem_rdata;
    logic         busy;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  iop_req, iop_we, iop_addr, iop_wdata,
        input  mem_rdata,
        output cpu_ack, cpu_rdata, iop_ack, iop_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata, busy
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output iop_req, iop_we, iop_addr, iop_wdata,
        output mem_rdata,
        input  cpu_ack, cpu_rdata, iop_ack, iop_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata, busy
    );
endinterface

// File: rtl/memory_port_arbiter.sv
// Shares core memory between the CPU and the IOP: one registered access at a time,
// IOP priority with a starvation guard that eventually forces a CPU grant.
module memory_port_arbiter #(
    parameter int unsigned MEM_CYCLES   = 2,
    parameter int unsigned STARVE_LIMIT = 3
) (
    input  logic                  clock,
    input  logic                  reset,
    memory_port_arbiter_if.slave  bus
);
    localparam int unsigned CW = $clog2(MEM_CYCLES + 1);
    localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);

    typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, ACK = 2'd2} state_t;

    state_t        state;
    logic          owner_iop;
    logic [CW-1:0] cnt;
    logic [SW-1:0] starve;
    logic          cpu_wins;

    always_comb begin
        cpu_wins = bus.cpu_req && (!bus.iop_req || (starve == SW'(STARVE_LIMIT)));
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            owner_iop     <= 1'b0;
            cnt           <= '0;
            starve        <= '0;
            bus.cpu_ack   <= 1'b0;
            bus.cpu_rdata <= '0;
            bus.iop_ack   <= 1'b0;
            bus.iop_rdata <= '0;
            bus.mem_en    <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
            bus.busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.cpu_req || bus.iop_req) begin
                        owner_iop     <= !cpu_wins;
                        bus.mem_addr  <= cpu_wins ? bus.cpu_addr  : bus.iop_addr;
                        bus.mem_we    <= cpu_wins ? bus.cpu_we    : bus.iop_we;
                        bus.mem_wdata <= cpu_wins ? bus.cpu_wdata : bus.iop_wdata;
                        bus.mem_en    <= 1'b1;
                        bus.busy      <= 1'b1;
                        cnt           <= CW'(MEM_CYCLES - 1);
                        state         <= BUSY;
                    end
                    // Falling into the else-if means an IOP grant while the CPU waits.
                    if (!bus.cpu_req || cpu_wins)
                        starve <= '0;
                    else if (starve != SW'(STARVE_LIMIT))
                        starve <= starve + 1'b1;
                end
                BUSY: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        bus.mem_en <= 1'b0;
                        bus.mem_we <= 1'b0;
                        if (owner_iop) begin
                            bus.iop_ack <= 1'b1;
                            if (!bus.mem_we) bus.iop_rdata <= bus.mem_rdata;
                        end else begin
                            bus.cpu_ack <= 1'b1;
                            if (!bus.mem_we) bus.cpu_rdata <= bus.mem_rdata;
                        end
                        state <= ACK;
                    end
                end
                ACK: begin
                    bus.cpu_ack <= 1'b0;
                    bus.iop_ack <= 1'b0;
                    bus.busy    <= 1'b0;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_memory_port_arbiter.sv
// Directed bench for memory_port_arbiter: one instance with MEM_CYCLES=2 and one with
// MEM_CYCLES=1, each backed by a small memory model.
module tb_memory_port_arbiter;
    logic clock = 1'b0;
    logic reset = 1'b1;
    int   n_checks = 0;
    int   n_fail = 0;

    always #5 clock = ~clock;

    memory_port_arbiter_if a();
    memory_port_arbiter_if b();

    memory_port_arbiter #(.MEM_CYCLES(2), .STARVE_LIMIT(3)) dut_a (
        .clock(clock), .reset(reset), .bus(a.slave));
    memory_port_arbiter #(.MEM_CYCLES(1), .STARVE_LIMIT(3)) dut_b (
        .clock(clock), .reset(reset), .bus(b.slave));

    // Memory models; instance a only presents valid data on the last mem_en cycle.
    logic [0:31]  mem_a [0:131071];
    logic [0:31]  mem_b [0:255];
    logic         pl_en = 1'b0;
    logic         pl_sel = 1'b0;
    logic [16:0]  pl_addr = '0;
    logic [31:0]  pl_data = '0;
    int unsigned  en_cnt_a = 0;

    always @(posedge clock) begin
        if (pl_en && !pl_sel) mem_a[pl_addr] <= pl_data;
        else if (a.mem_en && a.mem_we) mem_a[a.mem_addr] <= a.mem_wdata;
        if (pl_en && pl_sel) mem_b[pl_addr[7:0]] <= pl_data;
        else if (b.mem_en && b.mem_we) mem_b[b.mem_addr[24:31]] <= b.mem_wdata;
        en_cnt_a <= a.mem_en ? en_cnt_a + 1 : 0;
    end

    assign a.mem_rdata = (a.mem_en && en_cnt_a == 1) ? mem_a[a.mem_addr] : 32'hBAD0_BAD0;
    assign b.mem_rdata = b.mem_en ? mem_b[b.mem_addr[24:31]] : 32'hBAD0_BAD0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clock);
        #2;
    endtask

    task automatic preload(input logic sel, input logic [16:0] addr, input logic [31:0] data);
        pl_sel  = sel;
        pl_addr = addr;
        pl_data = data;
        pl_en   = 1'b1;
        cyc();
        pl_en   = 1'b0;
    endtask

    always @(negedge clock) begin
        chk("a_dual_ack", {31'b0, a.cpu_ack & a.iop_ack}, 32'h0);
        chk("a_we_no_en", {31'b0, a.mem_we & ~a.mem_en}, 32'h0);
        chk("b_dual_ack", {31'b0, b.cpu_ack & b.iop_ack}, 32'h0);
    end

    initial begin
        a.cpu_req = 0; a.cpu_we = 0; a.cpu_addr = '0; a.cpu_wdata = '0;
        a.iop_req = 0; a.iop_we = 0; a.iop_addr = '0; a.iop_wdata = '0;
        b.cpu_req = 0; b.cpu_we = 0; b.cpu_addr = '0; b.cpu_wdata = '0;
        b.iop_req = 0; b.iop_we = 0; b.iop_addr = '0; b.iop_wdata = '0;

        preload(1'b0, 17'h00010, 32'h1234_5678);
        preload(1'b0, 17'h00020, 32'hCAFE_F00D);
        preload(1'b1, 17'h00044, 32'hA5A5_0001);
        chk("rst_busy", {31'b0, a.busy}, 32'h0);
        chk("rst_mem_en", {31'b0, a.mem_en}, 32'h0);
        chk("rst_mem_addr", {15'b0, a.mem_addr}, 32'h0);
        chk("rst_cpu_rdata", a.cpu_rdata, 32'h0);
        chk("rst_iop_ack", {31'b0, a.iop_ack}, 32'h0);
        reset = 1'b0;
        cyc();

        // CPU read, two-cycle memory
        a.cpu_req = 1; a.cpu_we = 0; a.cpu_addr = 17'h00010;
        cyc();
        chk("t1_en1", {31'b0, a.mem_en}, 32'h1);
        chk("t1_addr", {15'b0, a.mem_addr}, 32'h10);
        chk("t1_we", {31'b0, a.mem_we}, 32'h0);
        chk("t1_busy", {31'b0, a.busy}, 32'h1);
        cyc();
        chk("t1_en2", {31'b0, a.mem_en}, 32'h1);
        chk("t1_ack_early", {31'b0, a.cpu_ack}, 32'h0);
        cyc();
        chk("t1_ack", {31'b0, a.cpu_ack}, 32'h1);
        chk("t1_rdata", a.cpu_rdata, 32'h1234_5678);
        chk("t1_en_off", {31'b0, a.mem_en}, 32'h0);
        a.cpu_req = 0;
        cyc();
        chk("t1_ack_pulse", {31'b0, a.cpu_ack}, 32'h0);
        chk("t1_idle", {31'b0, a.busy}, 32'h0);
        chk("t1_rdata_held", a.cpu_rdata, 32'h1234_5678);

        // Simultaneous requests: IOP write first, then CPU read
        a.cpu_req = 1; a.cpu_we = 0; a.cpu_addr = 17'h00020;
        a.iop_req = 1; a.iop_we = 1; a.iop_addr = 17'h00030; a.iop_wdata = 32'hDEAD_BEEF;
        cyc();
        chk("t2_iop_we", {31'b0, a.mem_we}, 32'h1);
        chk("t2_iop_addr", {15'b0, a.mem_addr}, 32'h30);
        chk("t2_iop_wdata", a.mem_wdata, 32'hDEAD_BEEF);
        cyc();
        cyc();
        chk("t2_iop_ack", {31'b0, a.iop_ack}, 32'h1);
        chk("t2_cpu_noack", {31'b0, a.cpu_ack}, 32'h0);
        a.iop_req = 0;
        cyc();
        chk("t2_idle", {31'b0, a.busy}, 32'h0);
        cyc();
        chk("t2_cpu_en", {31'b0, a.mem_en}, 32'h1);
        chk("t2_cpu_addr", {15'b0, a.mem_addr}, 32'h20);
        cyc();
        cyc();
        chk("t2_cpu_ack", {31'b0, a.cpu_ack}, 32'h1);
        chk("t2_cpu_rdata", a.cpu_rdata, 32'hCAFE_F00D);
        a.cpu_req = 0;
        cyc();

        // Both held: IOP, IOP, IOP, CPU (starvation guard), IOP
        a.cpu_req = 1; a.cpu_we = 0; a.cpu_addr = 17'h00010;
        a.iop_req = 1; a.iop_we = 0; a.iop_addr = 17'h00030;
        for (int g = 0; g < 5; g++) begin
            repeat ((g == 0) ? 3 : 4) cyc();
            chk($sformatf("t3_iop_ack_%0d", g), {31'b0, a.iop_ack}, (g != 3) ? 32'h1 : 32'h0);
            chk($sformatf("t3_cpu_ack_%0d", g), {31'b0, a.cpu_ack}, (g == 3) ? 32'h1 : 32'h0);
            if (g == 0) chk("t3_iop_rdata", a.iop_rdata, 32'hDEAD_BEEF);
            if (g == 3) chk("t3_cpu_rdata", a.cpu_rdata, 32'h1234_5678);
        end
        a.cpu_req = 0; a.iop_req = 0;
        cyc();

        // CPU write at top address, then read back
        a.cpu_req = 1; a.cpu_we = 1; a.cpu_addr = 17'h1FFFF; a.cpu_wdata = 32'h0005_5A5A;
        cyc();
        chk("t4_we1", {31'b0, a.mem_we}, 32'h1);
        chk("t4_addr1", {15'b0, a.mem_addr}, 32'h1FFFF);
        cyc();
        chk("t4_we2", {31'b0, a.mem_we}, 32'h1);
        chk("t4_wdata", a.mem_wdata, 32'h0005_5A5A);
        cyc();
        chk("t4_ack", {31'b0, a.cpu_ack}, 32'h1);
        chk("t4_we_off", {31'b0, a.mem_we}, 32'h0);
        chk("t4_rdata_kept", a.cpu_rdata, 32'h1234_5678);
        a.cpu_req = 0;
        cyc();
        a.cpu_req = 1; a.cpu_we = 0;
        repeat (3) cyc();
        chk("t4_rb_ack", {31'b0, a.cpu_ack}, 32'h1);
        chk("t4_rb_rdata", a.cpu_rdata, 32'h0005_5A5A);
        a.cpu_req = 0;
        cyc();

        // Reset in the second BUSY cycle abandons the access
        a.cpu_req = 1; a.cpu_we = 0; a.cpu_addr = 17'h00010;
        cyc();
        cyc();
        chk("t5_en_before", {31'b0, a.mem_en}, 32'h1);
        #1 reset = 1'b1;
        #1;
        chk("t5_en_async", {31'b0, a.mem_en}, 32'h0);
        chk("t5_busy_async", {31'b0, a.busy}, 32'h0);
        chk("t5_rdata_clr", a.cpu_rdata, 32'h0);
        a.cpu_req = 0;
        cyc();
        chk("t5_no_ack", {31'b0, a.cpu_ack}, 32'h0);
        reset = 1'b0;
        cyc();
        a.cpu_req = 1;
        repeat (3) cyc();
        chk("t5_post_ack", {31'b0, a.cpu_ack}, 32'h1);
        chk("t5_post_rdata", a.cpu_rdata, 32'h1234_5678);
        a.cpu_req = 0;
        cyc();

        // Single-cycle memory; request dropped during BUSY still completes
        b.cpu_req = 1; b.cpu_we = 0; b.cpu_addr = 17'h00044;
        cyc();
        chk("t6_en", {31'b0, b.mem_en}, 32'h1);
        chk("t6_ack_early", {31'b0, b.cpu_ack}, 32'h0);
        b.cpu_req = 0;
        cyc();
        chk("t6_ack", {31'b0, b.cpu_ack}, 32'h1);
        chk("t6_en_off", {31'b0, b.mem_en}, 32'h0);
        chk("t6_rdata", b.cpu_rdata, 32'hA5A5_0001);
        cyc();
        chk("t6_ack_pulse", {31'b0, b.cpu_ack}, 32'h0);
        chk("t6_idle", {31'b0, b.busy}, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
